sipo_deser: RTL
===============

Name: sipo_deser

Overview:
Parametrised serial-in parallel-out deserialiser, the successor to the fixed 4-bit SIPO register.
- Generalises the word width and adds selectable shift direction.
- Counts bits internally, captures each completed word automatically and presents it on a valid/ready output handshake with overrun detection.
- Sits between a serial line receiver (one bit per qualified clock) and a word-wide consumer.

Parameters:
- WIDTH, 8, parallel word width in bits; legal range 2 to 64.
- MSB_FIRST, 1. When 1, the first received bit ends in p_out[WIDTH-1]. When 0, the first received bit ends in p_out[0].
- CNT_W, $clog2(WIDTH), localparam; width of the bit counter.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- s_in, input, 1, serial data bit.
- s_valid, input, 1, s_in is sampled on this edge.
- clear, input, 1, synchronous frame restart.
- p_out, output, WIDTH, last captured word (registered).
- p_valid, output, 1, p_out holds an unconsumed word.
- p_ready, input, 1, consumer accepts p_out this cycle.
- overrun, output, 1, sticky flag: a completed word was dropped.
- bit_cnt, output, CNT_W, bits received in the current partial word.

Behaviour:
- Reset (rst=1, asynchronous, any time): shift reg, p_out, bit_cnt = 0; p_valid = 0; overrun = 0. Reset mid-word discards the partial word.
- Shift, on an edge with s_valid=1:
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], s_in}.
  - MSB_FIRST=0: sr <= {s_in, sr[WIDTH-1:1]}.
  - s_valid=0: sr and bit_cnt hold.
- Counter: bit_cnt increments on each s_valid; it wraps to 0 on the edge where bit_cnt==WIDTH-1 and s_valid=1 (word completion).
- Capture: on word completion, the assembled word, including the bit sampled that edge, is the candidate word.
  - If p_valid=0, or p_valid=1 with p_ready=1: p_out <= candidate, p_valid <= 1.
  - Latency: p_valid is high in the cycle after the edge that sampled the last bit.
- Handshake:
  - Transfer occurs on an edge with p_valid=1 and p_ready=1.
  - With no simultaneous completion: p_valid <= 0 and p_out holds its value.
  - p_out is stable while p_valid=1 and no transfer occurs.
  - p_ready is ignored while p_valid=0.
- Overrun: word completion while p_valid=1 and p_ready=0:
  - The candidate is dropped; p_out and p_valid are unchanged.
  - overrun <= 1 and stays set until clear or rst.
  - The next word still assembles normally; bit_cnt wraps to 0.
- Clear: clear=1 has priority over s_valid on the same edge. It sets sr <= 0, bit_cnt <= 0, overrun <= 0, p_valid <= 0; p_out holds. s_in is not sampled on that edge.
- Back-to-back words (s_valid held high): one word every WIDTH cycles. With p_ready held high there is no loss and no bubble.
- All outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package sipo_pkg:
  - Direction constants SIPO_MSB_FIRST=1 and SIPO_LSB_FIRST=0.
  - Width-helper clog2 function, reused by the future PISO and universal shift register.
- One sub-module is natural: sipo_bit_ctr.
  - Parametrised modulo-WIDTH counter with inc, clr and a wrap output.
  - Instantiated once; it supplies bit_cnt and the word-completion strobe.
- The shift register, capture register and handshake/overrun logic stay in sipo_deser.

Test Plan:
- Reset mid-word: WIDTH=8, MSB_FIRST=1, shift 3 bits, pulse rst between edges -> p_out=0, bit_cnt=0, p_valid=0, overrun=0 immediately (asynchronous).
- MSB-first capture: bits 1,0,1,1,0,0,1,0 with s_valid=1 -> p_out=8'hB2, p_valid=1 the cycle after the 8th edge; bit_cnt back to 0.
- LSB-first capture: MSB_FIRST=0, same bit sequence -> p_out=8'h4D.
- Gapped input: same 8 bits as above with s_valid low every other cycle -> bit_cnt holds during gaps; p_out=8'hB2 after 8 qualified bits.
- Overrun: p_ready=0, send 8'hB2 then 8'h0F continuously -> p_out stays 8'hB2, overrun=1 after the 16th bit. Then p_ready=1 for 1 cycle -> p_valid=0. Then clear -> overrun=0.
- Simultaneous transfer and completion: p_ready=1 on the edge completing a second word 8'hA5 -> p_out=8'hA5, p_valid stays 1, overrun=0. clear asserted together with s_valid -> bit_cnt=0, bit not shifted.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared definitions for the shift-register family (SIPO, PISO, universal).
package sipo_pkg;

  localparam bit SIPO_MSB_FIRST = 1'b1;
  localparam bit SIPO_LSB_FIRST = 1'b0;

  // Elaboration-time ceil(log2(value)); 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/sipo_bit_ctr.sv
// Modulo-MOD bit counter; wrap strobes combinationally on the increment that returns it to 0.
module sipo_bit_ctr
  import sipo_pkg::*;
#(
  parameter int MOD = 8,
  parameter int W   = clog2(MOD)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  // clr wins over inc, so a restart edge never reports a completion.
  assign wrap = inc && !clr && (cnt == W'(MOD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || wrap) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// Serial-in parallel-out deserialiser with valid/ready word output and sticky overrun flag.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = SIPO_MSB_FIRST,
  localparam int CNT_W    = clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_in,
  input  logic             s_valid,
  input  logic             clear,
  output logic [WIDTH-1:0] p_out,
  output logic             p_valid,
  input  logic             p_ready,
  output logic             overrun,
  output logic [CNT_W-1:0] bit_cnt
);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic             complete;

  generate
    if (MSB_FIRST != SIPO_LSB_FIRST) begin : g_msb
      assign sr_next = {sr[WIDTH-2:0], s_in};
    end else begin : g_lsb
      assign sr_next = {s_in, sr[WIDTH-1:1]};
    end
  endgenerate

  sipo_bit_ctr #(
    .MOD (WIDTH),
    .W   (CNT_W)
  ) u_bit_ctr (
    .clk  (clk),
    .rst  (rst),
    .inc  (s_valid),
    .clr  (clear),
    .cnt  (bit_cnt),
    .wrap (complete)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else if (clear) begin
      sr <= '0;
    end else if (s_valid) begin
      sr <= sr_next;
    end
  end

  // sr_next is the candidate: it already contains the bit sampled on the completing edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_out   <= '0;
      p_valid <= 1'b0;
      overrun <= 1'b0;
    end else if (clear) begin
      p_valid <= 1'b0;
      overrun <= 1'b0;
    end else if (complete) begin
      if (!p_valid || p_ready) begin
        p_out   <= sr_next;
        p_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (p_valid && p_ready) begin
      p_valid <= 1'b0;
    end
  end

endmodule
